// File: rtl/dda_pkg.sv
// Shared types and default widths for the DDA move sequencer and its tick generator.
package dda_pkg;

  localparam int DDA_BITS_DEF      = 64;
  localparam int DURATION_BITS_DEF = 32;
  localparam int DIVISOR_BITS_DEF  = 8;

  typedef struct packed {
    logic [DURATION_BITS_DEF-1:0] duration;
    logic [DDA_BITS_DEF-1:0]      increment;
    logic [DDA_BITS_DEF-1:0]      incrementincrement;
    logic                         dir;
  } move_t;

  typedef enum logic [1:0] {IDLE, LOAD, EXECUTE} seq_state_t;

endpackage

// File: rtl/dda_tick_gen.sv
// Free-running divider producing the square-wave dda_tick and a one-cycle tick_seen
// pulse aligned with the cycle in which dda_tick is first seen high.
module dda_tick_gen
  import dda_pkg::*;
#(
  parameter int DIVISOR_BITS = DIVISOR_BITS_DEF
) (
  input  logic                    CLK,
  input  logic                    resetn,
  input  logic [DIVISOR_BITS-1:0] clock_divisor,
  output logic                    dda_tick,
  output logic                    tick_seen
);

  logic [DIVISOR_BITS-1:0] count;
  logic                    wrap;

  assign wrap = (count == clock_divisor);

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      count     <= '0;
      dda_tick  <= 1'b0;
      tick_seen <= 1'b0;
    end else begin
      count     <= wrap ? '0 : count + 1'b1;
      tick_seen <= wrap && !dda_tick;
      if (wrap) dda_tick <= ~dda_tick;
    end
  end

endmodule

// File: rtl/dda_move_sequencer.sv
// Double-buffered move feeder for the DDA step timer (holding slot + active move).
// Optional abort support is compiled in when MOVE_ABORT_EN is defined.
module dda_move_sequencer
  import dda_pkg::*;
#(
  parameter int DDA_BITS      = DDA_BITS_DEF,
  parameter int DURATION_BITS = DURATION_BITS_DEF,
  parameter int DIVISOR_BITS  = DIVISOR_BITS_DEF
) (
  input  logic                     CLK,
  input  logic                     resetn,
  input  logic [DIVISOR_BITS-1:0]  clock_divisor,
  input  logic                     move_valid,
  output logic                     move_ready,
  input  logic [DURATION_BITS-1:0] move_duration,
  input  logic [DDA_BITS-1:0]      move_increment,
  input  logic [DDA_BITS-1:0]      move_incrementincrement,
  input  logic                     move_dir,
  output logic [DDA_BITS-1:0]      increment,
  output logic [DDA_BITS-1:0]      incrementincrement,
  output logic                     dir,
  output logic                     loading_move,
  output logic                     executing_move,
  output logic                     dda_tick,
  output logic                     move_done,
`ifdef MOVE_ABORT_EN
  input  logic                     abort,
  output logic                     abort_done,
`endif
  output logic                     busy
);

  seq_state_t               state, state_next;
  move_t                    hold;
  logic                     hold_full, hold_full_next;
  logic                     ready_q;
  logic [DURATION_BITS-1:0] remaining;
  logic                     tick_seen, accept, drain, load, completing, abort_i;

  dda_tick_gen #(.DIVISOR_BITS(DIVISOR_BITS)) u_tick_gen (
    .CLK          (CLK),
    .resetn       (resetn),
    .clock_divisor(clock_divisor),
    .dda_tick     (dda_tick),
    .tick_seen    (tick_seen)
  );

`ifdef MOVE_ABORT_EN
  assign abort_i = abort;
`else
  assign abort_i = 1'b0;
`endif

  // A move offered in an abort cycle must be refused, so ready is masked combinationally.
  assign move_ready     = ready_q & ~abort_i;
  assign accept         = move_valid & move_ready;
  assign completing     = (state == EXECUTE) && tick_seen && (remaining == DURATION_BITS'(1));
  assign load           = drain && (hold.duration != '0);
  assign loading_move   = (state == LOAD);
  assign executing_move = (state == EXECUTE);
  assign busy           = (state != IDLE) || hold_full;

  // NOTE: every always_comb output gets a default first, so no path can infer a latch.
  always_comb begin
    state_next = state;
    drain      = 1'b0;
    move_done  = 1'b0;
    case (state)
      IDLE: begin
        if (hold_full) begin
          drain = 1'b1;
          if (hold.duration == '0) move_done  = 1'b1;
          else                     state_next = LOAD;
        end
      end
      LOAD: state_next = EXECUTE;
      EXECUTE: begin
        if (completing) begin
          move_done = 1'b1;
          // A zero-length successor is left for IDLE to consume with its own done pulse.
          if (hold_full && hold.duration != '0) begin
            drain      = 1'b1;
            state_next = LOAD;
          end else begin
            state_next = IDLE;
          end
        end
      end
      default: state_next = IDLE;
    endcase
    if (abort_i) begin
      state_next = IDLE;
      drain      = 1'b0;
      move_done  = 1'b0;
    end
    hold_full_next = abort_i ? 1'b0 : ((hold_full & ~drain) | accept);
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_next;
  end

  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) begin
      hold               <= '0;
      hold_full          <= 1'b0;
      ready_q            <= 1'b0;
      remaining          <= '0;
      increment          <= '0;
      incrementincrement <= '0;
      dir                <= 1'b0;
    end else begin
      hold_full <= hold_full_next;
      ready_q   <= ~hold_full_next;
      if (accept) begin
        hold <= '{duration: move_duration, increment: move_increment,
                  incrementincrement: move_incrementincrement, dir: move_dir};
      end
      if (load) begin
        increment          <= hold.increment;
        incrementincrement <= hold.incrementincrement;
        dir                <= hold.dir;
        remaining          <= hold.duration;
      end else if (state == EXECUTE && tick_seen) begin
        remaining <= remaining - 1'b1;
      end
    end
  end

`ifdef MOVE_ABORT_EN
  always_ff @(posedge CLK or negedge resetn) begin
    if (!resetn) abort_done <= 1'b0;
    else         abort_done <= abort_i;
  end
`endif

endmodule

// File: tb/tb_dda_move_sequencer.sv
// Scoreboard bench for dda_move_sequencer: stimulus pushes expected moves, a negedge monitor checks them.
module tb_dda_move_sequencer;

  logic        CLK = 1'b0;
  logic        resetn;
  logic [7:0]  clock_divisor;
  logic        move_valid;
  logic        move_ready;
  logic [31:0] move_duration;
  logic [63:0] move_increment, move_incrementincrement;
  logic        move_dir;
  logic [63:0] increment, incrementincrement;
  logic        dir, loading_move, executing_move, dda_tick, move_done, busy;
  logic        abort_sig;
`ifdef MOVE_ABORT_EN
  logic        abort_done;
`endif

  dda_move_sequencer dut (
    .CLK                    (CLK),
    .resetn                 (resetn),
    .clock_divisor          (clock_divisor),
    .move_valid             (move_valid),
    .move_ready             (move_ready),
    .move_duration          (move_duration),
    .move_increment         (move_increment),
    .move_incrementincrement(move_incrementincrement),
    .move_dir               (move_dir),
    .increment              (increment),
    .incrementincrement     (incrementincrement),
    .dir                    (dir),
    .loading_move           (loading_move),
    .executing_move         (executing_move),
    .dda_tick               (dda_tick),
    .move_done              (move_done),
`ifdef MOVE_ABORT_EN
    .abort                  (abort_sig),
    .abort_done             (abort_done),
`endif
    .busy                   (busy)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    int unsigned dur;
    logic [63:0] inc;
    logic [63:0] incinc;
    logic        dir;
  } exp_t;

  exp_t exp_q[$];
  int   check_count = 0, pass_count = 0;
  int   cyc = 0, done_cyc = 0, load_gap = 0;
  int   ticks = 0, total_ticks = 0, load_count = 0, done_count = 0;
  logic active = 1'b0, tick_prev = 1'b0, prev_load = 1'b0, prev_done = 1'b0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    check_count++;
    if (act !== exp) $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    else pass_count++;
  endtask

  // Monitor: samples on the falling edge, away from the active edge.
  always @(negedge CLK) begin
    exp_t cur;
    logic rise;
    cyc++;
    rise      = dda_tick && !tick_prev;
    tick_prev = dda_tick;
    if (!resetn || abort_sig) begin
      if (resetn && abort_sig) check("abort_no_done", move_done, 1'b0);
      active    = 1'b0;
      prev_load = 1'b0;
      prev_done = 1'b0;
      exp_q.delete();
    end else begin
      if (prev_load) begin
        check("load_one_cycle", loading_move, 1'b0);
        check("exec_after_load", executing_move, 1'b1);
      end
      if (prev_done) check("exec_drop", executing_move, 1'b0);
      if (executing_move && rise) begin
        ticks++;
        total_ticks++;
      end
      if (loading_move) begin
        load_count++;
        load_gap = cyc - done_cyc;
        check("unexpected_load", exp_q.size(), 1);
        if (exp_q.size() > 0) begin
          cur = exp_q.pop_front();
          check("load_of_zero_move", cur.dur != 0, 1'b1);
          check("increment", increment, cur.inc);
          check("incrementincrement", incrementincrement, cur.incinc);
          check("dir", dir, cur.dir);
          exp_q.push_front(cur);
          active = 1'b1;
          ticks  = 0;
        end
      end
      if (move_done) begin
        done_count++;
        done_cyc = cyc;
        if (active) begin
          cur = exp_q.pop_front();
          check("ticks_per_move", ticks, cur.dur);
          active = 1'b0;
        end else begin
          check("unexpected_done", exp_q.size() > 0 && exp_q[0].dur == 0, 1'b1);
          if (exp_q.size() > 0) void'(exp_q.pop_front());
        end
      end
      prev_load = loading_move;
      prev_done = move_done;
    end
  end

  task automatic step(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic send(input int unsigned dur, input logic [63:0] inc, input logic [63:0] incinc,
                      input logic d);
    exp_t e;
    int   n = 0;
    move_valid              = 1'b1;
    move_duration           = dur;
    move_increment          = inc;
    move_incrementincrement = incinc;
    move_dir                = d;
    while (!move_ready && n < 500) begin
      step(1);
      n++;
    end
    check("send_timeout", n < 500, 1'b1);
    @(posedge CLK);
    e.dur = dur; e.inc = inc; e.incinc = incinc; e.dir = d;
    exp_q.push_back(e);
    #1;
    move_valid = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    while ((busy || executing_move) && n < 1000) begin
      step(1);
      n++;
    end
    check("idle_timeout", n < 1000, 1'b1);
  endtask

  task automatic wait_ticks(input int t);
    int n = 0;
    while (!(executing_move && ticks == t) && n < 500) begin
      step(1);
      n++;
    end
    check("tick_wait_timeout", n < 500, 1'b1);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int d0, l0;
    resetn = 1'b0; abort_sig = 1'b0; clock_divisor = 8'd1; move_valid = 1'b0;
    move_duration = '0; move_increment = '0; move_incrementincrement = '0; move_dir = 1'b0;
    step(3);
    check("rst_move_ready", move_ready, 1'b0);
    check("rst_busy", busy, 1'b0);
    check("rst_dda_tick", dda_tick, 1'b0);
    check("rst_increment", increment, 64'd0);
    check("rst_executing", executing_move, 1'b0);
    resetn = 1'b1;
    step(2);
    check("ready_after_reset", move_ready, 1'b1);

    // 1: single move, divisor 1
    d0 = done_count;
    send(4, 64'd10, 64'd0, 1'b0);
    wait_idle();
    check("t1_done_once", done_count - d0, 1);
    check("t1_increment_held", increment, 64'd10);

    // 2: back-to-back moves, divisor 0
    clock_divisor = 8'd0;
    total_ticks = 0; d0 = done_count;
    send(3, 64'd100, 64'd1, 1'b1);
    step(1);
    check("t2_first_load", loading_move, 1'b1);
    check("t2_ready_in_load", move_ready, 1'b1);
    send(2, 64'd200, 64'd2, 1'b0);
    wait_idle();
    check("t2_total_ticks", total_ticks, 5);
    check("t2_load_gap", load_gap, 1);
    check("t2_done_twice", done_count - d0, 2);

    // 3: zero-duration move followed by a normal one
    clock_divisor = 8'd1;
    d0 = done_count; l0 = load_count;
    send(0, 64'd77, 64'd0, 1'b1);
    wait_idle();
    check("t3_no_load", load_count - l0, 0);
    check("t3_done", done_count - d0, 1);
    send(2, 64'd5, 64'd3, 1'b1);
    wait_idle();
    check("t3_next_done", done_count - d0, 2);
    check("t3_next_load", load_count - l0, 1);

    // 4: stall with holding full; payload changes are not captured
    d0 = done_count;
    send(6, 64'd300, 64'd0, 1'b0);
    send(5, 64'd400, 64'd4, 1'b1);
    move_valid = 1'b1; move_duration = 32'd2; move_increment = 64'd500;
    for (int i = 0; i < 5; i++) begin
      step(1);
      check("t4_stalled_ready", move_ready, 1'b0);
      move_increment = 64'd600 + 64'(i);
    end
    move_valid = 1'b0;
    wait_idle();
    check("t4_done_two", done_count - d0, 2);
    check("t4_last_increment", increment, 64'd400);

    // 5: async reset mid-EXECUTE with remaining 7
    send(10, 64'd900, 64'd7, 1'b1);
    wait_ticks(3);
    #1 resetn = 1'b0;
    #1;
    check("t5_executing", executing_move, 1'b0);
    check("t5_loading", loading_move, 1'b0);
    check("t5_increment", increment, 64'd0);
    check("t5_incinc", incrementincrement, 64'd0);
    check("t5_dir", dir, 1'b0);
    check("t5_dda_tick", dda_tick, 1'b0);
    check("t5_busy", busy, 1'b0);
    check("t5_ready", move_ready, 1'b0);
    check("t5_done", move_done, 1'b0);
    step(2);
    resetn = 1'b1;
    d0 = done_count;
    step(3);
    check("t5_ready_after", move_ready, 1'b1);
    step(40);
    check("t5_no_done", done_count - d0, 0);
    check("t5_idle", busy, 1'b0);

`ifdef MOVE_ABORT_EN
    // 6: abort during EXECUTE with holding full
    d0 = done_count;
    send(8, 64'd11, 64'd0, 1'b0);
    send(3, 64'd22, 64'd0, 1'b1);
    wait_ticks(2);
    check("t6_holding_full", move_ready, 1'b0);
    abort_sig = 1'b1;
    step(1);
    abort_sig = 1'b0;
    check("t6_executing", executing_move, 1'b0);
    check("t6_abort_done", abort_done, 1'b1);
    check("t6_busy", busy, 1'b0);
    check("t6_ready", move_ready, 1'b1);
    step(1);
    check("t6_abort_done_pulse", abort_done, 1'b0);
    step(30);
    check("t6_no_done", done_count - d0, 0);
`endif

    $display("%0d/%0d checks passed", pass_count, check_count);
    $finish;
  end

endmodule
